// File: rtl/mem_packet_reader_if.sv
// Flit stream bundle between the packet reader and the router's local input.
// Ports: tx_data/tx_valid/tx_last from the source, tx_ready from the sink.
// Modports: master (packet source), slave (flit sink).
interface mem_packet_reader_if #(
  parameter int MEMORY_BUS_WIDTH = 32
);
  logic [MEMORY_BUS_WIDTH-1:0] tx_data;
  logic                        tx_valid;
  logic                        tx_last;
  logic                        tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/mem_packet_reader.sv
// Drains one packet (header + header[LEN_W-1:0] payload words) from the packet RAM onto a flit stream.
// Latency: start at edge N -> header read in cycle N+1 -> first tx_valid in cycle N+2, then 1 word/cycle.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; the RAM read address holds with them.
// Ports: clock/reset (sync, active-high), start/base_addr request, busy/done status,
//   rd_* RAM port A (read), clr_* RAM port B (write-back), tx flit stream interface (master).
// Option: define MEM_PACKET_READER_CLEAR_EN to write each consumed word back to all-ones via port B;
//   otherwise every clr_* output is tied to 0.
module mem_packet_reader #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int SIZE             = 1024,
  parameter int ADDR_W           = $clog2(SIZE),
  parameter int LEN_W            = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  output logic                        busy,
  output logic                        done,
  output logic                        rd_enable_out,
  output logic                        rd_wb_out,
  output logic [ADDR_W-1:0]           rd_addr_out,
  input  logic [MEMORY_BUS_WIDTH-1:0] rd_data_in,
  output logic                        clr_enable_out,
  output logic                        clr_wb_out,
  output logic [ADDR_W-1:0]           clr_addr_out,
  output logic [MEMORY_BUS_WIDTH-1:0] clr_data_out,
  mem_packet_reader_if.master         tx
);

  typedef enum logic [1:0] {IDLE = 2'd0, HEAD = 2'd1, SEND = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           ptr_q, ptr_d;
  logic [LEN_W-1:0]            rem_q, rem_d;
  logic [MEMORY_BUS_WIDTH-1:0] data_q, data_d;
  logic                        vld_q, vld_d;
  logic                        done_q, done_d;
  logic [ADDR_W-1:0]           ptr_nxt;
  logic                        hs;
`ifdef MEM_PACKET_READER_CLEAR_EN
  // Address of the word currently held in tx_data; only port B needs it.
  logic [ADDR_W-1:0]           cur_q, cur_d;
`endif

  // Wrap explicitly: SIZE need not be a power of two.
  assign ptr_nxt = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
  assign hs      = (state_q == SEND) && vld_q && tx.tx_ready;

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEM_PACKET_READER_CLEAR_EN
      cur_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
`ifdef MEM_PACKET_READER_CLEAR_EN
      cur_q   <= cur_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
`ifdef MEM_PACKET_READER_CLEAR_EN
    cur_d   = cur_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = base_addr;
          state_d = HEAD;
        end
      end
      HEAD: begin
        data_d  = rd_data_in;
        vld_d   = 1'b1;
        rem_d   = rd_data_in[LEN_W-1:0];
        ptr_d   = ptr_nxt;
`ifdef MEM_PACKET_READER_CLEAR_EN
        cur_d   = ptr_q;
`endif
        state_d = SEND;
      end
      SEND: begin
        if (hs) begin
          if (rem_q == '0) begin
            vld_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            // rd_addr_out already points at ptr, so the next word is on rd_data_in now.
            data_d = rd_data_in;
            ptr_d  = ptr_nxt;
            rem_d  = rem_q - 1'b1;
`ifdef MEM_PACKET_READER_CLEAR_EN
            cur_d  = ptr_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    rd_enable_out  = 1'b0;
    rd_addr_out    = '0;
    clr_enable_out = 1'b0;
    clr_wb_out     = 1'b0;
    clr_addr_out   = '0;
    clr_data_out   = '0;
    case (state_q)
      HEAD: begin
        rd_enable_out = 1'b1;
        rd_addr_out   = ptr_q;
      end
      SEND: begin
        rd_enable_out = (rem_q != '0);
        rd_addr_out   = ptr_q;
      end
      default: ;
    endcase
`ifdef MEM_PACKET_READER_CLEAR_EN
    // Write-back lands on the same edge that consumes the word.
    if (hs) begin
      clr_enable_out = 1'b1;
      clr_wb_out     = 1'b1;
      clr_addr_out   = cur_q;
      clr_data_out   = {MEMORY_BUS_WIDTH{1'b1}};
    end
`endif
  end

  assign rd_wb_out   = 1'b0;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign tx.tx_data  = data_q;
  assign tx.tx_valid = vld_q;
  assign tx.tx_last  = vld_q && (state_q == SEND) && (rem_q == '0);

endmodule

// File: tb/tb_mem_packet_reader.sv
// Directed bench for mem_packet_reader with a behavioural dual-port RAM model.
// Latency/flow expectations are hand-derived constants; flits are collected by handshake.
// Build with MEM_PACKET_READER_CLEAR_EN defined to also cover the write-back path.
module tb_mem_packet_reader;

  localparam int W    = 32;
  localparam int SIZE = 1024;
  localparam int AW   = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy, done;
  logic          rd_enable_out, rd_wb_out;
  logic [AW-1:0] rd_addr_out;
  logic [W-1:0]  rd_data_in;
  logic          clr_enable_out, clr_wb_out;
  logic [AW-1:0] clr_addr_out;
  logic [W-1:0]  clr_data_out;
  logic          tx_ready;

  mem_packet_reader_if #(.MEMORY_BUS_WIDTH(W)) tx_if ();
  assign tx_if.tx_ready = tx_ready;

  mem_packet_reader #(.MEMORY_BUS_WIDTH(W), .SIZE(SIZE), .ADDR_W(AW), .LEN_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done),
    .rd_enable_out(rd_enable_out), .rd_wb_out(rd_wb_out), .rd_addr_out(rd_addr_out),
    .rd_data_in(rd_data_in),
    .clr_enable_out(clr_enable_out), .clr_wb_out(clr_wb_out),
    .clr_addr_out(clr_addr_out), .clr_data_out(clr_data_out),
    .tx(tx_if)
  );

  always #5 clock = ~clock;

  // RAM model: combinational read on port A, clocked writes from the bench and port B.
  logic [W-1:0]  mem [SIZE];
  logic          tb_we;
  logic [AW-1:0] tb_wa;
  logic [W-1:0]  tb_wd;
  assign rd_data_in = mem[rd_addr_out];
  always @(posedge clock) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    if (clr_enable_out && clr_wb_out) mem[clr_addr_out] <= clr_data_out;
  end

  int n_chk = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic         last_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  task automatic load10();
    wr(10'd10, 32'h0000_0003);
    wr(10'd11, 32'h0000_000A);
    wr(10'd12, 32'h0000_000B);
    wr(10'd13, 32'h0000_000C);
  endtask

  // Returns at the negedge of the HEAD cycle.
  task automatic pulse_start(input logic [AW-1:0] a);
    start = 1'b1; base_addr = a;
    @(negedge clock);
    start = 1'b0;
  endtask

  // mode 0: tx_ready always high; mode 1: pattern 1,0,0 repeating. poke: start pulse while busy.
  task automatic collect(input int mode, input bit poke);
    bit           stalled = 1'b0;
    bit           got_done = 1'b0;
    logic [W-1:0] held = '0;
    got_q.delete(); last_q.delete();
    for (int k = 0; k < 60 && !got_done; k++) begin
      @(negedge clock);
      if (done) begin
        got_done = 1'b1;
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end else begin
        if (stalled) begin
          check("hold_vld", {31'd0, tx_if.tx_valid}, 32'd1);
          check("hold_dat", tx_if.tx_data, held);
        end
        tx_ready  = (mode == 0) ? 1'b1 : (k % 3 == 0);
        start     = poke && (k == 2);
        base_addr = '0;
        if (tx_if.tx_valid && tx_ready) begin
          got_q.push_back(tx_if.tx_data);
          last_q.push_back(tx_if.tx_last);
        end
        stalled = tx_if.tx_valid && !tx_ready;
        held    = tx_if.tx_data;
      end
    end
    start = 1'b0; tx_ready = 1'b1;
    check("done_seen", {31'd0, got_done}, 32'd1);
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_cnt"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
      check($sformatf("%s_l%0d", tag, i), {31'd0, last_q[i]}, {31'd0, (i == exp_q.size() - 1)});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; tx_ready = 1'b1;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    @(negedge clock);
    // Reset state.
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_vld",   {31'd0, tx_if.tx_valid}, 32'd0);
    check("rst_last",  {31'd0, tx_if.tx_last}, 32'd0);
    check("rst_data",  tx_if.tx_data, 32'd0);
    check("rst_rden",  {31'd0, rd_enable_out}, 32'd0);
    check("rst_rdwb",  {31'd0, rd_wb_out}, 32'd0);
    check("rst_rdad",  {22'd0, rd_addr_out}, 32'd0);
    check("rst_clren", {31'd0, clr_enable_out}, 32'd0);
    check("rst_clrwb", {31'd0, clr_wb_out}, 32'd0);
    load10();
    wr(10'd0, 32'hABCD_0000);
    reset = 1'b0;
    @(negedge clock);

    // Test 1: full-rate packet at 10, cycle-exact.
    pulse_start(10'd10);
    check("t1_head_busy", {31'd0, busy}, 32'd1);
    check("t1_head_vld",  {31'd0, tx_if.tx_valid}, 32'd0);
    check("t1_head_rden", {31'd0, rd_enable_out}, 32'd1);
    check("t1_head_addr", {22'd0, rd_addr_out}, 32'd10);
    tx_ready = 1'b1;
    exp_q = '{32'h3, 32'hA, 32'hB, 32'hC};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("t1_vld%0d", i),  {31'd0, tx_if.tx_valid}, 32'd1);
      check($sformatf("t1_dat%0d", i),  tx_if.tx_data, exp_q[i]);
      check($sformatf("t1_last%0d", i), {31'd0, tx_if.tx_last}, {31'd0, (i == 3)});
      check($sformatf("t1_wb%0d", i),   {31'd0, rd_wb_out}, 32'd0);
    end
    @(negedge clock);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_vld",  {31'd0, tx_if.tx_valid}, 32'd0);
    @(negedge clock);
    check("t1_done_pulse", {31'd0, done}, 32'd0);
`ifdef MEM_PACKET_READER_CLEAR_EN
    for (int a = 10; a < 14; a++) check($sformatf("clr_m%0d", a), mem[a], 32'hFFFF_FFFF);
`endif

    // Test 2: stalled stream plus an ignored start while busy.
    load10();
    pulse_start(10'd10);
    collect(1, 1'b1);
    exp_q = '{32'h3, 32'hA, 32'hB, 32'hC};
    compare_q("t2");
    @(negedge clock);
    check("t2_idle_after", {31'd0, busy}, 32'd0);

    // Test 3: length-0 header at address 0.
    pulse_start(10'd0);
    collect(0, 1'b0);
    exp_q = '{32'hABCD_0000};
    compare_q("t3");

    // Test 4: wrap from SIZE-2.
    wr(10'd1022, 32'h0000_0003);
    wr(10'd1023, 32'h0000_0011);
    wr(10'd0,    32'h0000_0022);
    wr(10'd1,    32'h0000_0033);
    pulse_start(10'd1022);
    collect(0, 1'b0);
    exp_q = '{32'h3, 32'h11, 32'h22, 32'h33};
    compare_q("t4");

    // Test 5: reset after the 2nd flit, then a clean restart.
    load10();
    tx_ready = 1'b1;
    pulse_start(10'd10);
    @(negedge clock);
    check("t5_f0", tx_if.tx_data, 32'h3);
    @(negedge clock);
    check("t5_f1", tx_if.tx_data, 32'hA);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5_vld",  {31'd0, tx_if.tx_valid}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    check("t5_done2", {31'd0, done}, 32'd0);
    load10();
    pulse_start(10'd10);
    collect(0, 1'b0);
    exp_q = '{32'h3, 32'hA, 32'hB, 32'hC};
    compare_q("t5");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
